if_fetch: RTL and testbench

//   Instruction fetch stage. Holds the fetch PC and issues in-order word reads to instruction memory.

---
 rtl/if_fetch_pkg.sv | 19 +
 rtl/if_fetch_if.sv | 39 +++
 rtl/if_fifo.sv | 47 ++++
 rtl/if_fetch.sv | 114 +++++++++++
 tb/tb_if_fetch.sv | 366 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/if_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// The IF_MISALIGN_EXC_EN build option adds the fetch_err output.
package if_fetch_pkg;

    localparam int XLEN   = 32;
    localparam int INST_W = 32;

    localparam logic [XLEN-1:0] PC_STEP = 32'd4;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [XLEN-1:0]   addr;
    } fetch_ent_t;

    function automatic logic [XLEN-1:0] pc_inc(input logic [XLEN-1:0] pc);
        return pc + PC_STEP;
    endfunction

endpackage

// File: rtl/if_fetch_if.sv
// Fetch-stage bus bundle: imem request/response, redirect and decoder side.
// fetch_err exists only when IF_MISALIGN_EXC_EN is defined.
interface if_fetch_if;
    import if_fetch_pkg::*;

    logic              imem_req;
    logic [XLEN-1:0]   imem_addr;
    logic              imem_ready;
    logic              imem_rvalid;
    logic [INST_W-1:0] imem_rdata;
    logic              redirect_valid;
    logic [XLEN-1:0]   redirect_pc;
    logic              id_ready;
    logic              inst_valid;
    logic [INST_W-1:0] inst;
    logic [XLEN-1:0]   addr;
`ifdef IF_MISALIGN_EXC_EN
    logic              fetch_err;
`endif

    modport master (
        output imem_req, imem_addr, inst_valid, inst, addr,
`ifdef IF_MISALIGN_EXC_EN
        output fetch_err,
`endif
        input  imem_ready, imem_rvalid, imem_rdata,
        input  redirect_valid, redirect_pc, id_ready
    );

    modport slave (
        input  imem_req, imem_addr, inst_valid, inst, addr,
`ifdef IF_MISALIGN_EXC_EN
        input  fetch_err,
`endif
        output imem_ready, imem_rvalid, imem_rdata,
        output redirect_valid, redirect_pc, id_ready
    );

endinterface

// File: rtl/if_fifo.sv
// Synchronous prefetch FIFO with flush and occupancy count.
// DEPTH must be a power of two so the pointers wrap naturally.
module if_fifo #(
    parameter  int DEPTH = 2,
    parameter  int W     = 64,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          pop,
    output logic [W-1:0]  dout,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q;
    logic [AW-1:0] rd_q;
    logic [CW-1:0] cnt_q;

    // Pointer and count bookkeeping; flush empties without touching storage.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push) wr_q <= wr_q + AW'(1);
            if (pop)  rd_q <= rd_q + AW'(1);
            cnt_q <= cnt_q + CW'(push) - CW'(pop);
        end
    end

    // Entry storage, written at the tail.
    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[wr_q] <= din;
    end

    assign dout  = mem_q[rd_q];
    assign empty = (cnt_q == '0);
    assign count = cnt_q;

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch stage: credit-limited imem reads into a prefetch FIFO.
// Define IF_MISALIGN_EXC_EN to trap misaligned redirects on fetch_err.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
    parameter int              FIFO_DEPTH = 2
) (
    input logic        clk,
    input logic        rst,
    if_fetch_if.master bus
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] rsp_pc_q;
    logic [CW-1:0]   outst_q;
    logic [CW-1:0]   disc_q;
    logic [CW-1:0]   fifo_cnt;
    logic [CW:0]     credit_use;
    logic            req;
    logic            accept;
    logic            rsp;
    logic            push;
    logic            pop;
    logic            empty;
    logic            err_q;
    logic            redir_bad;
    logic [XLEN-1:0] redir_pc;
    fetch_ent_t      din;
    fetch_ent_t      dout;

`ifdef IF_MISALIGN_EXC_EN
    assign redir_bad = bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00);
    assign redir_pc  = bus.redirect_pc;

    // Sticky misalignment flag, updated by every redirect.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (bus.redirect_valid) begin
            err_q <= redir_bad;
        end
    end

    assign bus.fetch_err = err_q;
`else
    assign redir_bad = 1'b0;
    assign redir_pc  = bus.redirect_pc & ~32'h3;
    assign err_q     = 1'b0;
`endif

    // Reads in flight plus buffered words never exceed the FIFO depth.
    assign credit_use = {1'b0, outst_q} + {1'b0, fifo_cnt};
    assign req        = !rst && !bus.redirect_valid && !err_q &&
                        (credit_use < (CW+1)'(FIFO_DEPTH));
    assign accept     = req && bus.imem_ready;
    assign rsp        = bus.imem_rvalid && (outst_q != '0);
    assign push       = rsp && !bus.redirect_valid && (disc_q == '0);
    assign pop        = !empty && bus.id_ready && !bus.redirect_valid;

    assign din.inst = bus.imem_rdata;
    assign din.addr = pc_inc(rsp_pc_q);

    // Fetch PC, response PC and in-flight/discard counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q     <= RESET_PC;
            rsp_pc_q <= RESET_PC;
            outst_q  <= '0;
            disc_q   <= '0;
        end else begin
            outst_q <= outst_q + CW'(accept) - CW'(rsp);
            if (bus.redirect_valid) begin
                disc_q <= outst_q - CW'(rsp);
                if (!redir_bad) begin
                    pc_q     <= redir_pc;
                    rsp_pc_q <= redir_pc;
                end
            end else begin
                if (rsp && (disc_q != '0)) disc_q <= disc_q - CW'(1);
                if (accept) pc_q     <= pc_inc(pc_q);
                if (push)   rsp_pc_q <= pc_inc(rsp_pc_q);
            end
        end
    end

    if_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     ($bits(fetch_ent_t))
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (bus.redirect_valid),
        .push  (push),
        .din   (din),
        .pop   (pop),
        .dout  (dout),
        .empty (empty),
        .count (fifo_cnt)
    );

    assign bus.imem_req   = req;
    assign bus.imem_addr  = pc_q;
    assign bus.inst_valid = !empty;
    assign bus.inst       = empty ? '0 : dout.inst;
    assign bus.addr       = empty ? '0 : dout.addr;

    rvalid_needs_outstanding: assert property (
        @(posedge clk) disable iff (rst) bus.imem_rvalid |-> (outst_q != '0)
    );

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch with an in-order, fixed-latency imem model.
// Build with IF_MISALIGN_EXC_EN to cover the fetch_err path.
module tb_if_fetch;

    localparam logic [31:0] K = 32'hDEAD_0000;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    int   cyc;
    int   lat;

    logic [31:0] pend_addr[$];
    int          pend_due[$];
    logic [31:0] acc_log[$];
    logic [31:0] pop_inst[$];
    logic [31:0] pop_addr[$];

    if_fetch_if bus ();

    if_fetch #(
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        logic        acc;
        logic [31:0] a;
        #1;
        acc = bus.imem_req && bus.imem_ready;
        a   = bus.imem_addr;
        if (!rst && bus.inst_valid && bus.id_ready && !bus.redirect_valid) begin
            pop_inst.push_back(bus.inst);
            pop_addr.push_back(bus.addr);
        end
        if (bus.imem_rvalid && pend_addr.size() > 0) begin
            void'(pend_addr.pop_front());
            void'(pend_due.pop_front());
        end
        @(posedge clk);
        #1;
        cyc++;
        bus.redirect_valid = 1'b0;
        if (rst) begin
            pend_addr.delete();
            pend_due.delete();
        end else if (acc) begin
            acc_log.push_back(a);
            pend_addr.push_back(a);
            pend_due.push_back(cyc + lat - 1);
        end
        if (!rst && pend_addr.size() > 0 && pend_due[0] <= cyc) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = pend_addr[0] ^ K;
        end else begin
            bus.imem_rvalid = 1'b0;
            bus.imem_rdata  = '0;
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.redirect_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        cyc = 0;
        acc_log.delete();
        pop_inst.delete();
        pop_addr.delete();
    endtask

    task automatic redirect(input logic [31:0] pc);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = pc;
        #1;
    endtask

    task automatic test_reset();
        lat = 1;
        bus.id_ready = 1'b1;
        rst = 1'b1;
        tick();
        total++;
        if (bus.imem_req !== 1'b0 || bus.inst_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_ctl req=%b vld=%b exp 0 0", bus.imem_req, bus.inst_valid);
        end
        total++;
        if (bus.inst !== 32'h0 || bus.addr !== 32'h0) begin
            bad++;
            $display("FAIL reset_data inst=%h addr=%h exp 0 0", bus.inst, bus.addr);
        end
        do_reset();
        bus.id_ready = 1'b0;
        repeat (4) tick();
        total++;
        if (bus.inst_valid !== 1'b1) begin
            bad++;
            $display("FAIL pre_mid_reset vld=%b exp 1", bus.inst_valid);
        end
        rst = 1'b1;
        redirect(32'h0000_0300);
        tick();
        total++;
        if (bus.inst_valid !== 1'b0 || bus.imem_req !== 1'b0 || bus.inst !== 32'h0) begin
            bad++;
            $display("FAIL mid_reset vld=%b req=%b inst=%h exp 0 0 0",
                     bus.inst_valid, bus.imem_req, bus.inst);
        end
        rst = 1'b0;
        #1;
        total++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin
            bad++;
            $display("FAIL reset_wins req=%b addr=%h exp 1 00000000",
                     bus.imem_req, bus.imem_addr);
        end
        bus.id_ready = 1'b1;
    endtask

    task automatic test_stream();
        lat = 1;
        bus.id_ready = 1'b1;
        do_reset();
        total++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin
            bad++;
            $display("FAIL first_req req=%b addr=%h exp 1 00000000", bus.imem_req, bus.imem_addr);
        end
        tick();
        total++;
        if (bus.inst_valid !== 1'b0) begin
            bad++;
            $display("FAIL no_bypass vld=%b exp 0", bus.inst_valid);
        end
        tick();
        total++;
        if (bus.inst_valid !== 1'b1 || bus.addr !== 32'h4 || bus.inst !== K) begin
            bad++;
            $display("FAIL first_inst vld=%b addr=%h inst=%h exp 1 00000004 %h",
                     bus.inst_valid, bus.addr, bus.inst, K);
        end
        repeat (12) tick();
        total++;
        if (acc_log.size() < 4) begin
            bad++;
            $display("FAIL stream_reqs got=%0d exp>=4", acc_log.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                total++;
                if (acc_log[i] !== 32'(4 * i)) begin
                    bad++;
                    $display("FAIL stream_addr[%0d] got=%h exp=%h", i, acc_log[i], 32'(4 * i));
                end
            end
        end
    endtask

    task automatic test_stall();
        lat = 1;
        bus.id_ready = 1'b0;
        do_reset();
        repeat (10) tick();
        total++;
        if (acc_log.size() != 2 || bus.imem_req !== 1'b0) begin
            bad++;
            $display("FAIL stall_credit reqs=%0d req=%b exp 2 0", acc_log.size(), bus.imem_req);
        end
        total++;
        if (pop_addr.size() != 0 || bus.inst_valid !== 1'b1) begin
            bad++;
            $display("FAIL stall_hold pops=%0d vld=%b exp 0 1", pop_addr.size(), bus.inst_valid);
        end
        bus.id_ready = 1'b1;
        repeat (12) tick();
        total++;
        if (pop_addr.size() < 4) begin
            bad++;
            $display("FAIL drain_count got=%0d exp>=4", pop_addr.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                total++;
                if (pop_addr[i] !== 32'(4 * i + 4) || pop_inst[i] !== (32'(4 * i) ^ K)) begin
                    bad++;
                    $display("FAIL drain[%0d] addr=%h inst=%h exp %h %h", i, pop_addr[i],
                             pop_inst[i], 32'(4 * i + 4), 32'(4 * i) ^ K);
                end
            end
        end
    endtask

    task automatic test_redirect_inflight();
        lat = 3;
        bus.id_ready = 1'b1;
        do_reset();
        tick();
        tick();
        total++;
        if (bus.imem_req !== 1'b0 || acc_log.size() != 2) begin
            bad++;
            $display("FAIL inflight_two req=%b reqs=%0d exp 0 2", bus.imem_req, acc_log.size());
        end
        redirect(32'h0000_0100);
        tick();
        total++;
        if (bus.inst_valid !== 1'b0) begin
            bad++;
            $display("FAIL rd_flush vld=%b exp 0", bus.inst_valid);
        end
        for (int n = 0; n < 30 && pop_addr.size() == 0; n++) tick();
        total++;
        if (pop_addr.size() == 0) begin
            bad++;
            $display("FAIL rd_timeout no inst after redirect");
        end else if (pop_addr[0] !== 32'h104 || pop_inst[0] !== (32'h100 ^ K)) begin
            bad++;
            $display("FAIL rd_first addr=%h inst=%h exp 00000104 %h",
                     pop_addr[0], pop_inst[0], 32'h100 ^ K);
        end
    endtask

    task automatic test_redirect_rvalid();
        lat = 1;
        bus.id_ready = 1'b1;
        do_reset();
        tick();
        tick();
        total++;
        if (bus.inst_valid !== 1'b1) begin
            bad++;
            $display("FAIL rv_setup vld=%b exp 1", bus.inst_valid);
        end
        redirect(32'h0000_0040);
        tick();
        total++;
        if (bus.inst_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h40) begin
            bad++;
            $display("FAIL rv_after vld=%b req=%b addr=%h exp 0 1 00000040",
                     bus.inst_valid, bus.imem_req, bus.imem_addr);
        end
        for (int n = 0; n < 30 && pop_addr.size() == 0; n++) tick();
        total++;
        if (pop_addr.size() == 0) begin
            bad++;
            $display("FAIL rv_timeout no inst after redirect");
        end else if (pop_addr[0] !== 32'h44 || pop_inst[0] !== (32'h40 ^ K)) begin
            bad++;
            $display("FAIL rv_first addr=%h inst=%h exp 00000044 %h",
                     pop_addr[0], pop_inst[0], 32'h40 ^ K);
        end
    endtask

    task automatic test_wrap();
        lat = 1;
        bus.id_ready = 1'b1;
        do_reset();
        redirect(32'hFFFF_FFFC);
        tick();
        total++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'hFFFF_FFFC) begin
            bad++;
            $display("FAIL wrap_req req=%b addr=%h exp 1 fffffffc", bus.imem_req, bus.imem_addr);
        end
        repeat (8) tick();
        total++;
        if (acc_log.size() < 2 || pop_addr.size() < 2) begin
            bad++;
            $display("FAIL wrap_count reqs=%0d pops=%0d exp>=2", acc_log.size(), pop_addr.size());
        end else begin
            total++;
            if (acc_log[1] !== 32'h0) begin
                bad++;
                $display("FAIL wrap_addr got=%h exp 00000000", acc_log[1]);
            end
            total++;
            if (pop_addr[0] !== 32'h0 || pop_inst[0] !== (32'hFFFF_FFFC ^ K) ||
                pop_addr[1] !== 32'h4) begin
                bad++;
                $display("FAIL wrap_pop a0=%h i0=%h a1=%h exp 00000000 %h 00000004",
                         pop_addr[0], pop_inst[0], pop_addr[1], 32'hFFFF_FFFC ^ K);
            end
        end
    endtask

    task automatic test_misalign();
        lat = 1;
        bus.id_ready = 1'b1;
        do_reset();
        redirect(32'h0000_0102);
        tick();
`ifdef IF_MISALIGN_EXC_EN
        total++;
        if (bus.fetch_err !== 1'b1 || bus.imem_req !== 1'b0) begin
            bad++;
            $display("FAIL ma_set err=%b req=%b exp 1 0", bus.fetch_err, bus.imem_req);
        end
        repeat (3) tick();
        total++;
        if (bus.imem_req !== 1'b0 || acc_log.size() != 0) begin
            bad++;
            $display("FAIL ma_hold req=%b reqs=%0d exp 0 0", bus.imem_req, acc_log.size());
        end
        redirect(32'h0000_0200);
        tick();
        total++;
        if (bus.fetch_err !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h200) begin
            bad++;
            $display("FAIL ma_clear err=%b req=%b addr=%h exp 0 1 00000200",
                     bus.fetch_err, bus.imem_req, bus.imem_addr);
        end
        for (int n = 0; n < 30 && pop_addr.size() == 0; n++) tick();
        total++;
        if (pop_addr.size() == 0 || pop_addr[0] !== 32'h204) begin
            bad++;
            $display("FAIL ma_restart pops=%0d exp first addr 00000204", pop_addr.size());
        end
`else
        total++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h100) begin
            bad++;
            $display("FAIL ma_align req=%b addr=%h exp 1 00000100", bus.imem_req, bus.imem_addr);
        end
        for (int n = 0; n < 30 && pop_addr.size() == 0; n++) tick();
        total++;
        if (pop_addr.size() == 0 || pop_addr[0] !== 32'h104) begin
            bad++;
            $display("FAIL ma_first pops=%0d exp first addr 00000104", pop_addr.size());
        end
`endif
    endtask

    initial begin
        total = 0;
        bad   = 0;
        cyc   = 0;
        lat   = 1;
        rst   = 1'b1;
        bus.imem_ready     = 1'b1;
        bus.imem_rvalid    = 1'b0;
        bus.imem_rdata     = '0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.id_ready       = 1'b1;
        test_reset();
        test_stream();
        test_stall();
        test_redirect_inflight();
        test_redirect_rvalid();
        test_wrap();
        test_misalign();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
